receiver: RTL and testbench



---
 rtl/receiver.sv | 146 ++++++++++++++
 tb/tb_receiver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// Bit-serial 802.11a PLCP receiver: preamble hunt/check, SIGNAL field decode,
// and LENGTH*8 payload bit forwarding with a valid strobe.
module receiver #(
  parameter int PREAMBLE_BITS = 96
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Input,
  output logic        Output,
  output logic        OutputValid,
  output logic [3:0]  Rate,
  output logic [11:0] Length,
  output logic        SignalValid,
  output logic        SignalError,
  output logic        PreambleError,
  output logic        FrameDone,
  output logic        Busy
);

  typedef enum logic [1:0] {HUNT, PREAMBLE, SIGNAL, PAYLOAD} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);
  localparam logic [7:0] SIG_LAST = 8'd23;

  state_t        state, state_nxt;
  logic [7:0]    bit_cnt, bit_cnt_nxt;
  logic [14:0]   pay_cnt, pay_cnt_nxt;
  logic [22:0]   sig_p0;
  logic [23:0]   sig_full;
  logic          out_nxt, ov_nxt, sv_nxt, se_nxt, pe_nxt, fd_nxt, busy_nxt;
  logic [3:0]    rate_nxt;
  logic [11:0]   len_nxt;

  // Reserved bit clear, even parity over bits 0..17, all-zero tail.
  function automatic logic sig_accept(input logic [23:0] s);
    return (s[4] == 1'b0) && ((^s[17:0]) == 1'b0) && (s[23:18] == 6'd0);
  endfunction

  // SIGNAL bits shift in from the top so bit k lands at position k after 23 shifts.
  always_ff @(posedge Clock) begin
    if (!Reset && state == SIGNAL)
      sig_p0 <= {Input, sig_p0[22:1]};
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    pay_cnt_nxt = pay_cnt;
    out_nxt     = 1'b0;
    ov_nxt      = 1'b0;
    rate_nxt    = Rate;
    len_nxt     = Length;
    sv_nxt      = 1'b0;
    se_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    fd_nxt      = 1'b0;
    sig_full    = {Input, sig_p0};

    case (state)
      HUNT: begin
        if (Input) begin
          state_nxt   = PREAMBLE;
          bit_cnt_nxt = 8'd1;
        end
      end
      PREAMBLE: begin
        if (Input != ~bit_cnt[0]) begin
          pe_nxt      = 1'b1;
          state_nxt   = HUNT;
          bit_cnt_nxt = 8'd0;
        end else if (bit_cnt == PRE_LAST) begin
          state_nxt   = SIGNAL;
          bit_cnt_nxt = 8'd0;
        end else begin
          bit_cnt_nxt = bit_cnt + 8'd1;
        end
      end
      SIGNAL: begin
        if (bit_cnt == SIG_LAST) begin
          bit_cnt_nxt = 8'd0;
          if (sig_accept(sig_full)) begin
            rate_nxt = sig_full[3:0];
            len_nxt  = sig_full[16:5];
            sv_nxt   = 1'b1;
            if (sig_full[16:5] == 12'd0) begin
              fd_nxt    = 1'b1;
              state_nxt = HUNT;
            end else begin
              state_nxt   = PAYLOAD;
              pay_cnt_nxt = {sig_full[16:5], 3'b000};
            end
          end else begin
            se_nxt    = 1'b1;
            state_nxt = HUNT;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 8'd1;
        end
      end
      PAYLOAD: begin
        out_nxt     = Input;
        ov_nxt      = 1'b1;
        pay_cnt_nxt = pay_cnt - 15'd1;
        if (pay_cnt == 15'd1) begin
          fd_nxt    = 1'b1;
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase

    // Busy stays up through the cycle carrying the terminating pulse.
    busy_nxt = (state_nxt != HUNT) || fd_nxt || se_nxt || pe_nxt;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= HUNT;
      bit_cnt       <= 8'd0;
      pay_cnt       <= 15'd0;
      Output        <= 1'b0;
      OutputValid   <= 1'b0;
      Rate          <= 4'd0;
      Length        <= 12'd0;
      SignalValid   <= 1'b0;
      SignalError   <= 1'b0;
      PreambleError <= 1'b0;
      FrameDone     <= 1'b0;
      Busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      pay_cnt       <= pay_cnt_nxt;
      Output        <= out_nxt;
      OutputValid   <= ov_nxt;
      Rate          <= rate_nxt;
      Length        <= len_nxt;
      SignalValid   <= sv_nxt;
      SignalError   <= se_nxt;
      PreambleError <= pe_nxt;
      FrameDone     <= fd_nxt;
      Busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for the PLCP receiver: table of SIGNAL-field frames plus
// hand sequences for preamble error, mid-frame reset and a maximum-length frame.
module tb_receiver;

  localparam int PRE = 96;

  logic        Clock, Reset, Input;
  logic        Output, OutputValid, SignalValid, SignalError, PreambleError, FrameDone, Busy;
  logic [3:0]  Rate;
  logic [11:0] Length;

  receiver #(.PREAMBLE_BITS(PRE)) dut (
    .Clock(Clock), .Reset(Reset), .Input(Input),
    .Output(Output), .OutputValid(OutputValid),
    .Rate(Rate), .Length(Length),
    .SignalValid(SignalValid), .SignalError(SignalError),
    .PreambleError(PreambleError), .FrameDone(FrameDone), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  rate;
    logic [11:0] len;
    logic        resv;
    logic        par_flip;
    logic [5:0]  tail;
    int          gap;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [3:0]  exp_rate;
  logic [11:0] exp_len;
  logic [7:0]  pay [4096];

  // Monitor: sampled on the falling edge, away from the active edge.
  logic rx [65536];
  int ov_n = 0, fd_n = 0, sv_n = 0, se_n = 0, pe_n = 0, busy_n = 0;
  always @(negedge Clock) begin
    if (OutputValid) begin
      rx[ov_n & 65535] <= Output;
      ov_n <= ov_n + 1;
    end
    if (FrameDone)     fd_n   <= fd_n + 1;
    if (SignalValid)   sv_n   <= sv_n + 1;
    if (SignalError)   se_n   <= se_n + 1;
    if (PreambleError) pe_n   <= pe_n + 1;
    if (Busy)          busy_n <= busy_n + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    Input = b;
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    @(negedge Clock);
    #1;
  endtask

  // abort_at >= 0 stops after that many payload bits, skipping end-of-frame checks.
  task automatic send_frame(input vec_t v, input int abort_at);
    logic [23:0] sb;
    logic good;
    int ov0, fd0, pe0, nbits, errs;
    good = !v.resv && !v.par_flip && (v.tail == 6'd0);
    sb[3:0]   = v.rate;
    sb[4]     = v.resv;
    sb[16:5]  = v.len;
    sb[17]    = (^sb[16:0]) ^ v.par_flip;
    sb[23:18] = v.tail;
    nbits = good ? int'(v.len) * 8 : 0;
    ov0 = ov_n; fd0 = fd_n; pe0 = pe_n;
    for (int i = 0; i < PRE; i++) send_bit((i % 2) == 0);
    for (int i = 0; i < 24; i++) send_bit(sb[i]);
    if (good) begin
      exp_rate = v.rate;
      exp_len  = v.len;
    end
    chk("signal_valid", SignalValid, good);
    chk("signal_error", SignalError, !good);
    chk("rate", Rate, exp_rate);
    chk("length", Length, exp_len);
    if (good && v.len == 12'd0) chk("done_with_sv", FrameDone, 1'b1);
    for (int j = 0; j < nbits; j++) begin
      if (abort_at >= 0 && j == abort_at) return;
      send_bit(pay[j / 8][j % 8]);
    end
    if (nbits > 0) begin
      chk("done_last_bit", FrameDone, 1'b1);
      chk("valid_last_bit", OutputValid, 1'b1);
    end
    settle();
    chk("valid_count", ov_n - ov0, nbits);
    chk("done_count", fd_n - fd0, good ? 1 : 0);
    chk("preamble_err_count", pe_n - pe0, 0);
    if (nbits > 0) begin
      errs = 0;
      for (int k = 0; k < nbits; k++)
        if (rx[(ov0 + k) & 65535] !== pay[k / 8][k % 8]) errs++;
      chk("payload_data", errs, 0);
    end
    for (int g = 0; g < v.gap; g++) send_bit(1'b0);
    if (v.gap > 0) chk("busy_after_frame", Busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, Output, 1'b0);
    chk({tag, "_ov"}, OutputValid, 1'b0);
    chk({tag, "_rate"}, Rate, 4'd0);
    chk({tag, "_len"}, Length, 12'd0);
    chk({tag, "_sv"}, SignalValid, 1'b0);
    chk({tag, "_se"}, SignalError, 1'b0);
    chk({tag, "_pe"}, PreambleError, 1'b0);
    chk({tag, "_fd"}, FrameDone, 1'b0);
    chk({tag, "_busy"}, Busy, 1'b0);
  endtask

  vec_t tbl [6];
  vec_t v;
  int c0, c1, c2;

  initial begin
    tbl[0] = '{rate: 4'h6, len: 12'd2, resv: 1'b0, par_flip: 1'b0, tail: 6'd0,        gap: 2};
    tbl[1] = '{rate: 4'hB, len: 12'd3, resv: 1'b0, par_flip: 1'b1, tail: 6'd0,        gap: 2};
    tbl[2] = '{rate: 4'h3, len: 12'd5, resv: 1'b1, par_flip: 1'b0, tail: 6'd0,        gap: 2};
    tbl[3] = '{rate: 4'h9, len: 12'd7, resv: 1'b0, par_flip: 1'b0, tail: 6'b000100,   gap: 2};
    tbl[4] = '{rate: 4'hD, len: 12'd0, resv: 1'b0, par_flip: 1'b0, tail: 6'd0,        gap: 0};
    tbl[5] = '{rate: 4'h1, len: 12'd1, resv: 1'b0, par_flip: 1'b0, tail: 6'd0,        gap: 2};

    exp_rate = 4'd0;
    exp_len  = 12'd0;
    Reset = 1'b1;
    Input = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    chk_all_zero("reset");
    Reset = 1'b0;
    send_bit(1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < 4096; b++) pay[b] = 8'($urandom);
      if (t == 0) begin
        pay[0] = 8'hA5;
        pay[1] = 8'h3C;
      end
      send_frame(tbl[t], -1);
    end

    // Preamble with bit 40 flipped.
    c0 = pe_n; c1 = sv_n; c2 = ov_n;
    for (int i = 0; i < 41; i++) send_bit(i == 40 ? 1'b0 : ((i % 2) == 0));
    chk("pre_err_pulse", PreambleError, 1'b1);
    chk("pre_err_busy", Busy, 1'b1);
    send_bit(1'b0);
    chk("pre_err_one_cycle", PreambleError, 1'b0);
    chk("pre_err_hunt", Busy, 1'b0);
    repeat (4) send_bit(1'b0);
    settle();
    chk("pre_err_count", pe_n - c0, 1);
    chk("pre_err_no_sv", sv_n - c1, 0);
    chk("pre_err_no_ov", ov_n - c2, 0);
    chk("pre_err_rate", Rate, exp_rate);
    chk("pre_err_len", Length, exp_len);

    // Reset at payload bit 5 of a LENGTH=4 frame, then a full frame.
    for (int b = 0; b < 4096; b++) pay[b] = 8'($urandom);
    v = '{rate: 4'h5, len: 12'd4, resv: 1'b0, par_flip: 1'b0, tail: 6'd0, gap: 0};
    send_frame(v, 5);
    Reset = 1'b1;
    Input = pay[0][5];
    @(posedge Clock); #1;
    chk_all_zero("midreset");
    Reset = 1'b0;
    exp_rate = 4'd0;
    exp_len  = 12'd0;
    v.gap = 2;
    send_frame(v, -1);

    // Long idle, then a maximum-length frame.
    c0 = busy_n; c1 = ov_n;
    repeat (1000) send_bit(1'b0);
    settle();
    chk("idle_busy", busy_n - c0, 0);
    chk("idle_no_ov", ov_n - c1, 0);
    for (int b = 0; b < 4096; b++) pay[b] = 8'($urandom);
    v = '{rate: 4'hC, len: 12'd4095, resv: 1'b0, par_flip: 1'b0, tail: 6'd0, gap: 2};
    send_frame(v, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
